// File: rtl/mem_bus_sequencer_pkg.sv
// Shared types and constants for the memory bus sequencer: FSM states,
// access-size codes, requester identities and a size decoder.
package mem_bus_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BEAT = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_t;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Size code 3 is treated as a full word.
  function automatic logic [2:0] size_to_nbytes(input logic [1:0] size);
    case (size)
      SIZE_B:  size_to_nbytes = 3'd1;
      SIZE_H:  size_to_nbytes = 3'd2;
      default: size_to_nbytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_bus_sequencer_arb.sv
// Two-requester round-robin arbiter; the last-grant flop only moves when the
// parent says a grant was actually taken (advance high).
module rr_arbiter2
  import mem_bus_sequencer_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_if,
  input  logic req_d,
  input  logic advance,
  output logic grant_if,
  output logic grant_d
);

  port_t last_grant;

  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (req_if && req_d) begin
      if (last_grant == PORT_D) grant_if = 1'b1;
      else                      grant_d  = 1'b1;
    end else if (req_if) begin
      grant_if = 1'b1;
    end else if (req_d) begin
      grant_d = 1'b1;
    end
  end

  // Reset value makes the data port win the first contested round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= PORT_IF;
    end else if (advance) begin
      if (grant_if)     last_grant <= PORT_IF;
      else if (grant_d) last_grant <= PORT_D;
    end
  end

endmodule

// File: rtl/mem_bus_sequencer.sv
// Arbitrates fetch and load/store requests and serialises each access into
// little-endian byte beats on the 8-bit pin bus, assembling read data.
module mem_bus_sequencer
  import mem_bus_sequencer_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [7:0]  if_addr,
  output logic        if_ready,
  output logic        if_rsp,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [7:0]  d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic        d_rsp,
  output logic [31:0] rdata,
  output logic [7:0]  bus_addr,
  output logic [7:0]  bus_oe,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata
);

  localparam logic [1:0] LAT_LAST = 2'(READ_LAT - 1);

  state_t      state;
  state_t      state_next;
  port_t       owner;
  logic [7:0]  base_addr;
  logic        is_write;
  logic [2:0]  nbytes;
  logic [31:0] wdata_q;
  logic [1:0]  beat_cnt;
  logic [1:0]  lat_cnt;
  logic [1:0]  next_beat;
  logic        grant_if;
  logic        grant_d;
  logic        in_idle;
  logic        accept;
  logic        last_beat;
  logic        lat_done;

  assign in_idle   = (state == ST_IDLE);
  assign accept    = in_idle && (grant_if || grant_d);
  assign next_beat = beat_cnt + 2'd1;
  assign last_beat = ({1'b0, beat_cnt} == (nbytes - 3'd1));
  assign lat_done  = (lat_cnt == LAT_LAST);

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_if   (if_req),
    .req_d    (d_req),
    .advance  (in_idle),
    .grant_if (grant_if),
    .grant_d  (grant_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // A read beat is one BEAT cycle followed by READ_LAT WAIT cycles.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = ST_BEAT;
      ST_BEAT: begin
        if (!is_write)     state_next = ST_WAIT;
        else if (last_beat) state_next = ST_RESP;
      end
      ST_WAIT: if (lat_done) state_next = last_beat ? ST_RESP : ST_BEAT;
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    if_ready = rst_n && in_idle && grant_if;
    d_ready  = rst_n && in_idle && grant_d;
    if_rsp   = (state == ST_RESP) && (owner == PORT_IF);
    d_rsp    = (state == ST_RESP) && (owner == PORT_D);
    bus_oe   = ((state == ST_BEAT) && is_write) ? 8'hFF : 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner     <= PORT_D;
      base_addr <= 8'h00;
      is_write  <= 1'b0;
      nbytes    <= 3'd0;
      wdata_q   <= 32'h0;
      beat_cnt  <= 2'd0;
      lat_cnt   <= 2'd0;
      rdata     <= 32'h0;
      bus_addr  <= 8'h00;
      bus_wdata <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          beat_cnt <= 2'd0;
          lat_cnt  <= 2'd0;
          if (accept && grant_d) begin
            owner     <= PORT_D;
            base_addr <= d_addr;
            is_write  <= d_we;
            nbytes    <= size_to_nbytes(d_size);
            wdata_q   <= d_wdata;
            bus_addr  <= d_addr;
            if (d_we) bus_wdata <= d_wdata[7:0];
            else      rdata     <= 32'h0;
          end else if (accept) begin
            owner     <= PORT_IF;
            base_addr <= if_addr;
            is_write  <= 1'b0;
            nbytes    <= 3'd4;
            bus_addr  <= if_addr;
            rdata     <= 32'h0;
          end
        end
        ST_BEAT: begin
          lat_cnt <= 2'd0;
          if (is_write && !last_beat) begin
            beat_cnt  <= next_beat;
            bus_addr  <= base_addr + 8'(next_beat);
            bus_wdata <= wdata_q[{next_beat, 3'b000} +: 8];
          end
        end
        ST_WAIT: begin
          lat_cnt <= lat_cnt + 2'd1;
          if (lat_done) begin
            lat_cnt <= 2'd0;
            rdata[{beat_cnt, 3'b000} +: 8] <= bus_rdata;
            if (!last_beat) begin
              beat_cnt <= next_beat;
              bus_addr <= base_addr + 8'(next_beat);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_sequencer.sv
// Directed bench for mem_bus_sequencer: one READ_LAT=1 instance for most
// scenarios and a READ_LAT=3 instance for the long-latency fetch.
module tb_mem_bus_sequencer;
  import mem_bus_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_req, d_we;
  logic [7:0]  if_addr, d_addr;
  logic [1:0]  d_size;
  logic [31:0] d_wdata;
  logic        if_ready, if_rsp, d_ready, d_rsp;
  logic [31:0] rdata;
  logic [7:0]  bus_addr, bus_oe, bus_wdata, bus_rdata;

  logic        if_req3;
  logic [7:0]  if_addr3;
  logic        if_ready3, if_rsp3, d_ready3, d_rsp3;
  logic [31:0] rdata3;
  logic [7:0]  bus_addr3, bus_oe3, bus_wdata3, bus_rdata3;

  logic [7:0]  mem [0:255];

  int checks = 0;
  int errors = 0;

  logic [7:0]  rec_addr  [0:20];
  logic [7:0]  rec_oe    [0:20];
  logic [7:0]  rec_wd    [0:20];
  logic        rec_drsp  [0:20];
  logic [31:0] rec_rdata [0:20];

  always #5 clk = ~clk;

  assign bus_rdata  = mem[bus_addr];
  assign bus_rdata3 = mem[bus_addr3];

  mem_bus_sequencer #(.READ_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rsp(if_rsp),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rsp(d_rsp), .rdata(rdata),
    .bus_addr(bus_addr), .bus_oe(bus_oe), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  mem_bus_sequencer #(.READ_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req3), .if_addr(if_addr3), .if_ready(if_ready3), .if_rsp(if_rsp3),
    .d_req(1'b0), .d_we(1'b0), .d_size(2'd0), .d_addr(8'h00), .d_wdata(32'h0),
    .d_ready(d_ready3), .d_rsp(d_rsp3), .rdata(rdata3),
    .bus_addr(bus_addr3), .bus_oe(bus_oe3), .bus_wdata(bus_wdata3), .bus_rdata(bus_rdata3)
  );

  task automatic do_reset();
    rst_n = 1'b0;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_size = 2'd0;
    if_addr = 8'h00; d_addr = 8'h00; d_wdata = 32'h0;
    if_req3 = 1'b0; if_addr3 = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic issue_d(input logic we, input logic [1:0] size, input logic [7:0] addr,
                         input logic [31:0] wd);
    @(negedge clk);
    d_we = we; d_size = size; d_addr = addr; d_wdata = wd; d_req = 1'b1;
    #1;
    for (int i = 0; i < 20 && !d_ready; i++) begin
      @(negedge clk);
      #1;
    end
    checks++;
    if (d_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL d_ready_timeout: got %b, want 1", d_ready);
    end
    @(posedge clk);
    #1 d_req = 1'b0;
  endtask

  task automatic capture(input int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      rec_addr[k]  = bus_addr;
      rec_oe[k]    = bus_oe;
      rec_wd[k]    = bus_wdata;
      rec_drsp[k]  = d_rsp;
      rec_rdata[k] = rdata;
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (bus_addr !== 8'h00 || bus_oe !== 8'h00 || bus_wdata !== 8'h00 || rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_bus: addr=%h oe=%h wd=%h rdata=%h, want all zero",
               bus_addr, bus_oe, bus_wdata, rdata);
    end
    checks++;
    if (if_ready !== 1'b0 || d_ready !== 1'b0 || if_rsp !== 1'b0 || d_rsp !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_handshake: ifr=%b dr=%b ifrsp=%b drsp=%b, want 0",
               if_ready, d_ready, if_rsp, d_rsp);
    end
  endtask

  task automatic test_load_word();
    logic [7:0] exp_addr;
    issue_d(1'b0, SIZE_W, 8'h10, 32'h0);
    capture(10);
    for (int k = 1; k <= 8; k++) begin
      exp_addr = 8'h10 + 8'((k - 1) / 2);
      checks++;
      if (rec_addr[k] !== exp_addr || rec_oe[k] !== 8'h00) begin
        errors++;
        $display("[TB] FAIL load_word_beat k=%0d: addr=%h oe=%h, want addr=%h oe=00",
                 k, rec_addr[k], rec_oe[k], exp_addr);
      end
    end
    for (int k = 1; k <= 10; k++) begin
      checks++;
      if (rec_drsp[k] !== (k == 9)) begin
        errors++;
        $display("[TB] FAIL load_word_rsp k=%0d: got %b, want %b", k, rec_drsp[k], (k == 9));
      end
    end
    checks++;
    if (rec_rdata[9] !== 32'h44332211) begin
      errors++;
      $display("[TB] FAIL load_word_rdata: got %h, want 44332211", rec_rdata[9]);
    end
  endtask

  task automatic test_store_half();
    logic [7:0] ea [1:4];
    logic [7:0] eo [1:4];
    logic       er [1:4];
    ea = '{8'h20, 8'h21, 8'h21, 8'h21};
    eo = '{8'hFF, 8'hFF, 8'h00, 8'h00};
    er = '{1'b0, 1'b0, 1'b1, 1'b0};
    issue_d(1'b1, SIZE_H, 8'h20, 32'h0000BEEF);
    capture(4);
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (rec_addr[k] !== ea[k] || rec_oe[k] !== eo[k] || rec_drsp[k] !== er[k]) begin
        errors++;
        $display("[TB] FAIL store_half k=%0d: addr=%h oe=%h rsp=%b, want addr=%h oe=%h rsp=%b",
                 k, rec_addr[k], rec_oe[k], rec_drsp[k], ea[k], eo[k], er[k]);
      end
    end
    checks++;
    if (rec_wd[1] !== 8'hEF || rec_wd[2] !== 8'hBE) begin
      errors++;
      $display("[TB] FAIL store_half_data: got %h,%h, want EF,BE", rec_wd[1], rec_wd[2]);
    end
  endtask

  task automatic test_round_robin();
    int   grants;
    logic both_high;
    logic is_d [0:2];
    do_reset();
    @(negedge clk);
    grants = 0;
    both_high = 1'b0;
    d_we = 1'b0; d_size = SIZE_B; d_addr = 8'h30; if_addr = 8'h50;
    d_req = 1'b1; if_req = 1'b1;
    for (int c = 0; c < 100 && grants < 3; c++) begin
      #1;
      if (if_ready && d_ready) both_high = 1'b1;
      if (d_ready) begin
        is_d[grants] = 1'b1;
        grants++;
      end else if (if_ready) begin
        is_d[grants] = 1'b0;
        grants++;
      end
      if (grants < 3) @(negedge clk);
    end
    @(posedge clk);
    #1 d_req = 1'b0; if_req = 1'b0;
    checks++;
    if (grants != 3) begin
      errors++;
      $display("[TB] FAIL rr_grant_count: got %0d, want 3", grants);
    end else begin
      checks++;
      if (is_d[0] !== 1'b1 || is_d[1] !== 1'b0 || is_d[2] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL rr_order: got d=%b,%b,%b, want 1,0,1", is_d[0], is_d[1], is_d[2]);
      end
    end
    checks++;
    if (both_high !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rr_exclusive: both readies seen high=%b, want 0", both_high);
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_wrap_and_byte();
    logic [7:0] exp_addr;
    issue_d(1'b0, SIZE_W, 8'hFE, 32'h0);
    capture(10);
    for (int k = 1; k <= 8; k++) begin
      exp_addr = 8'hFE + 8'((k - 1) / 2);
      checks++;
      if (rec_addr[k] !== exp_addr) begin
        errors++;
        $display("[TB] FAIL wrap_addr k=%0d: got %h, want %h", k, rec_addr[k], exp_addr);
      end
    end
    checks++;
    if (rec_drsp[9] !== 1'b1 || rec_rdata[9] !== 32'hF0DEBC9A) begin
      errors++;
      $display("[TB] FAIL wrap_rdata: rsp=%b rdata=%h, want 1 F0DEBC9A", rec_drsp[9], rec_rdata[9]);
    end
    issue_d(1'b0, SIZE_B, 8'h05, 32'h0);
    capture(4);
    checks++;
    if (rec_addr[1] !== 8'h05 || rec_addr[2] !== 8'h05) begin
      errors++;
      $display("[TB] FAIL byte_addr: got %h,%h, want 05,05", rec_addr[1], rec_addr[2]);
    end
    checks++;
    if (rec_drsp[2] !== 1'b0 || rec_drsp[3] !== 1'b1 || rec_drsp[4] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL byte_rsp: got %b%b%b at k=2..4, want 010",
               rec_drsp[2], rec_drsp[3], rec_drsp[4]);
    end
    checks++;
    if (rec_rdata[3] !== 32'h000000A5) begin
      errors++;
      $display("[TB] FAIL byte_rdata: got %h, want 000000A5", rec_rdata[3]);
    end
  endtask

  task automatic test_reset_abort();
    logic saw_rsp;
    issue_d(1'b1, SIZE_W, 8'h60, 32'hDDCCBBAA);
    repeat (3) @(negedge clk);
    checks++;
    if (bus_addr !== 8'h62 || bus_oe !== 8'hFF || bus_wdata !== 8'hCC) begin
      errors++;
      $display("[TB] FAIL abort_beat2: addr=%h oe=%h wd=%h, want 62 FF CC",
               bus_addr, bus_oe, bus_wdata);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus_oe !== 8'h00) begin
      errors++;
      $display("[TB] FAIL abort_oe: got %h, want 00", bus_oe);
    end
    saw_rsp = 1'b0;
    @(negedge clk);
    if (d_rsp) saw_rsp = 1'b1;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (d_rsp) saw_rsp = 1'b1;
    end
    checks++;
    if (saw_rsp !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_no_rsp: d_rsp seen=%b, want 0", saw_rsp);
    end
    issue_d(1'b0, SIZE_B, 8'h05, 32'h0);
    capture(4);
    checks++;
    if (rec_drsp[3] !== 1'b1 || rec_rdata[3] !== 32'h000000A5) begin
      errors++;
      $display("[TB] FAIL abort_recover: rsp=%b rdata=%h, want 1 000000A5",
               rec_drsp[3], rec_rdata[3]);
    end
  endtask

  task automatic test_fetch_lat3();
    logic [7:0] exp_addr;
    logic       bad_addr;
    logic       bad_rsp;
    @(negedge clk);
    if_addr3 = 8'h40; if_req3 = 1'b1;
    #1;
    for (int i = 0; i < 20 && !if_ready3; i++) begin
      @(negedge clk);
      #1;
    end
    checks++;
    if (if_ready3 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL lat3_ready: got %b, want 1", if_ready3);
    end
    @(posedge clk);
    #1 if_req3 = 1'b0;
    bad_addr = 1'b0;
    bad_rsp  = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      exp_addr = 8'h40 + 8'((k - 1) / 4);
      if (k <= 16 && bus_addr3 !== exp_addr) begin
        bad_addr = 1'b1;
        $display("[TB] lat3 addr k=%0d: got %h, want %h", k, bus_addr3, exp_addr);
      end
      if (if_rsp3 !== (k == 17) || d_rsp3 !== 1'b0) bad_rsp = 1'b1;
      if (k == 17) begin
        checks++;
        if (rdata3 !== 32'hEFBEADDE) begin
          errors++;
          $display("[TB] FAIL lat3_rdata: got %h, want EFBEADDE", rdata3);
        end
      end
    end
    checks++;
    if (bad_addr !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lat3_addr_hold: mismatch flag=%b, want 0", bad_addr);
    end
    checks++;
    if (bad_rsp !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lat3_rsp_timing: mismatch flag=%b, want 0 (if_rsp only at cycle 17)", bad_rsp);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33; mem[8'h13] = 8'h44;
    mem[8'hFE] = 8'h9A; mem[8'hFF] = 8'hBC; mem[8'h00] = 8'hDE; mem[8'h01] = 8'hF0;
    mem[8'h05] = 8'hA5;
    mem[8'h40] = 8'hDE; mem[8'h41] = 8'hAD; mem[8'h42] = 8'hBE; mem[8'h43] = 8'hEF;

    test_reset();
    test_load_word();
    test_store_half();
    test_round_robin();
    test_wrap_and_byte();
    test_reset_abort();
    test_fetch_lat3();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
